// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the three-master system bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned ARB_MASTERS = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned IW = 2;

  localparam logic [IW-1:0] ARB_M_INST = 2'd0;
  localparam logic [IW-1:0] ARB_M_DATA = 2'd1;
  localparam logic [IW-1:0] ARB_M_AUX  = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  // Next master index, wrapping 2 -> 0 (an out-of-range index also wraps to 0).
  function automatic logic [IW-1:0] next_master(input logic [IW-1:0] idx);
    return (idx >= ARB_M_AUX) ? ARB_M_INST : idx + IW'(1);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: searches requests starting after the last winner.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [ARB_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [ARB_MASTERS-1:0] win,
  output logic [IW-1:0]          win_idx
);

  logic [IW-1:0] cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    cand    = next_master(last);
    for (int k = 0; k < int'(ARB_MASTERS); k++) begin
      if (req[cand] && (win == '0)) begin
        win[cand] = 1'b1;
        win_idx   = cand;
      end
      cand = next_master(cand);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus with burst hold and a stuck-slave watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ARB_MASTERS-1:0]    m_cyc,
  input  logic [ARB_MASTERS-1:0]    m_stb,
  input  logic [ARB_MASTERS-1:0]    m_we,
  input  logic [ARB_MASTERS*AW-1:0] m_addr,
  input  logic [ARB_MASTERS*SW-1:0] m_sel,
  input  logic [ARB_MASTERS*DW-1:0] m_dout,
  output logic [DW-1:0]             m_din,
  output logic [ARB_MASTERS-1:0]    m_ack,
  output logic [ARB_MASTERS-1:0]    m_err,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [AW-1:0]             s_addr,
  output logic [SW-1:0]             s_sel,
  output logic [DW-1:0]             s_dout,
  input  logic [DW-1:0]             s_din,
  input  logic                      s_ack,
  input  logic                      s_err,
  output logic [ARB_MASTERS-1:0]    grant,
  output logic                      timeout
);

  arb_state_e             state, state_next;
  logic [ARB_MASTERS-1:0] grant_next;
  logic [IW-1:0]          last, last_next;
  logic [TO_BITS-1:0]     cnt, cnt_next;

  logic [ARB_MASTERS-1:0] pick;
  logic [IW-1:0]          pick_idx;

  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_addr;
  logic [SW-1:0] own_sel;
  logic [DW-1:0] own_dout;

  rr_pick u_rr_pick (
    .req     (m_cyc),
    .last    (last),
    .win     (pick),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      grant   <= '0;
      last    <= ARB_M_AUX;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      last    <= last_next;
      cnt     <= cnt_next;
      timeout <= (state_next == ARB_ABORT);
    end
  end

  // Next state; the watchdog count falls back to zero on every path that does not extend a stall.
  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    cnt_next   = '0;
    case (state)
      ARB_IDLE: begin
        if (|m_cyc) begin
          state_next = ARB_BUSY;
          grant_next = pick;
          last_next  = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!own_cyc) begin
          state_next = ARB_IDLE;
          grant_next = '0;
        end else if (own_stb && !s_ack && !s_err) begin
          if (cnt == TO_BITS'(TIMEOUT - 1)) state_next = ARB_ABORT;
          else                              cnt_next   = cnt + TO_BITS'(1);
        end
      end
      ARB_ABORT: state_next = ARB_BUSY;
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Owner selection follows the one-hot grant so nothing leaks through while idle.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_sel  = '0;
    own_dout = '0;
    for (int i = 0; i < int'(ARB_MASTERS); i++) begin
      if (grant[i]) begin
        own_cyc  = m_cyc[i];
        own_stb  = m_stb[i];
        own_we   = m_we[i];
        own_addr = m_addr[AW*i +: AW];
        own_sel  = m_sel[SW*i +: SW];
        own_dout = m_dout[DW*i +: DW];
      end
    end
  end

  always_comb begin
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    s_we   = 1'b0;
    s_addr = '0;
    s_sel  = '0;
    s_dout = '0;
    m_ack  = '0;
    m_err  = '0;
    case (state)
      ARB_BUSY: begin
        s_cyc  = own_cyc;
        s_stb  = own_stb;
        s_we   = own_we;
        s_addr = own_addr;
        s_sel  = own_sel;
        s_dout = own_dout;
        m_ack  = grant & {ARB_MASTERS{s_ack}};
        m_err  = grant & {ARB_MASTERS{s_err}};
      end
      ARB_ABORT: m_err = grant;
      default: ;
    endcase
  end

  assign m_din = s_din;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the single system bus between the CPU's bus masters: m0 is instruction fetch (IMMU/ICACHE refill), m1 is data access (DMMU/DCACHE refill and write-back), and m2 is an auxiliary master (DMA/debug). The block sits between those masters and the shared bus. It grants the bus round-robin at whole-cycle (`cyc`) granularity and holds ownership through bursts. A watchdog aborts any strobe the slave never answers, so a missing device cannot hang the pipeline's `inst_stall`/`mem_stall`.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles a strobe may wait for `s_ack`/`s_err` before abort (1..65535).
- `TO_BITS`, default 16: width of the timeout counter.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `m_cyc` in 3: per-master bus cycle request; bit i belongs to master i.
- `m_stb` in 3: per-master strobe.
- `m_we` in 3: per-master write enable.
- `m_addr` in 96: packed addresses; master i uses `[32i+31:32i]`.
- `m_sel` in 12: packed byte selects; master i uses `[4i+3:4i]`.
- `m_dout` in 96: packed write data.
- `m_din` out 32: read data, broadcast to all masters.
- `m_ack` out 3: per-master acknowledge.
- `m_err` out 3: per-master error.
- `s_cyc`, `s_stb`, `s_we` out 1 each: muxed bus controls toward the slave.
- `s_addr` out 32, `s_sel` out 4, `s_dout` out 32: muxed address, byte selects and write data toward the slave.
- `s_din` in 32: slave read data.
- `s_ack`, `s_err` in 1 each: slave acknowledge and error.
- `grant` out 3: registered one-hot owner, 0 when the bus is idle.
- `timeout` out 1: one-cycle pulse when an abort fires.

## Operation
- FSM states: IDLE, BUSY, ABORT. Reset puts it in IDLE with `grant`=0, `last`=2, and the counter at 0.
- IDLE:
  - If any `m_cyc` is high, pick a winner round-robin, searching from `last+1` mod 3.
  - Register `grant`, set `last` to the winner, go to BUSY.
  - If no `m_cyc` is high, stay in IDLE.
- BUSY:
  - The owner's `cyc`/`stb`/`we`/`addr`/`sel`/`dout` drive `s_*` combinationally.
  - `s_ack` routes only to `m_ack[owner]` and `s_err` only to `m_err[owner]`.
  - `m_din` = `s_din` at all times.
  - Non-owners see `m_ack`=`m_err`=0 and wait. Their requests are neither lost nor latched.
  - When the owner's `m_cyc` is low, go to IDLE and clear `grant`.
- Burst hold: the owner keeps the bus while its `m_cyc` stays high, across any number of strobes. Gaps in `stb` do not release the bus.
- Watchdog:
  - The counter increments each BUSY cycle in which `s_stb`=1 and `s_ack`=`s_err`=0.
  - It clears on `s_ack`, on `s_err`, when `s_stb`=0, and on any state change.
  - When it reaches `TIMEOUT-1` with still no response, go to ABORT.
- ABORT (exactly 1 cycle):
  - `s_cyc`=`s_stb`=0.
  - `m_err[owner]`=1 and `timeout`=1.
  - Counter cleared, then return to BUSY with the same owner. The owner normally drops `cyc` next.
- Reset asserted mid-transfer: all outputs return to their reset values immediately and asynchronously, and the FSM goes to IDLE. There is no completion of the in-flight transfer.
- Reset value of every output: `s_cyc`=`s_stb`=`s_we`=0, `s_addr`=`s_sel`=`s_dout`=0, `m_ack`=`m_err`=0, `grant`=0, `timeout`=0. `m_din` follows `s_din`.

## Timing
- Grant latency: `m_cyc` rises at edge N, `grant` and `s_cyc` are valid after edge N+1. That is 1 cycle of arbitration, with no combinational path from `m_cyc` to `grant`.
- Owner handover: the owner drops `cyc` and the FSM goes BUSY→IDLE (1 cycle), then IDLE→BUSY for the next owner. This gives at least 1 dead cycle between owners, which guarantees `s_cyc` is low for at least one cycle at every ownership change.
- Data path: `s_*` follows the owner's inputs combinationally, and `m_ack`/`m_din` follow the slave combinationally. The arbiter adds zero data latency inside a grant.
- Timeout abort: `m_err` is asserted exactly `TIMEOUT` cycles after the first unanswered `s_stb` cycle.
- Simultaneous slave response and timeout threshold: if `s_ack` or `s_err` arrives in the threshold cycle, the slave response wins and no abort occurs.

## Structure
- Shared package/header (`define.vh` style):
  - state encodings `ARB_IDLE`, `ARB_BUSY`, `ARB_ABORT`;
  - master index constants `ARB_M_INST`=0, `ARB_M_DATA`=1, `ARB_M_AUX`=2;
  - master count `ARB_MASTERS`=3.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs are a 3-bit request vector and a 2-bit `last`. Output is the one-hot winner plus its index.
- The FSM, the timeout counter and the output mux live in `bus_arbiter`.

## Test plan
- Single master: m1 reads 0x0000_1000 and the slave acks 2 cycles after `stb`. Expect `grant`=3'b010 one cycle after `cyc`, `m_ack[1]` to pulse, `m_din`=`s_din`=0xDEADBEEF, and `m_ack[0]`=`m_ack[2]`=0.
- Contention from reset: all three raise `cyc` together. Expect grants in order m0, m1, m2 (`last`=2 at reset), each separated by an IDLE cycle with `s_cyc`=0.
- Burst hold: m0 issues 4 strobes with `cyc` held while m1 requests. Expect m1 not granted until m0 drops `cyc`, and all 4 `m_ack[0]` pulses delivered.
- Timeout: with `TIMEOUT`=8, m2 strobes and the slave never responds. Expect `m_err[2]`=1, `timeout`=1 and `s_cyc`=0 exactly 8 cycles after the first strobe cycle. After m2 drops `cyc`, expect `grant`=0.
- Late ack at threshold: with `TIMEOUT`=8, `s_ack` arrives in cycle 8. Expect `m_ack` asserted, no `m_err`, and no `timeout` pulse.
- Reset mid-burst: assert `rst_n`=0 asynchronously during an m1 write. Expect `s_cyc`=0 and `grant`=0 before the next clock edge. After release, m0's pending request is granted first.
